request_encoder: RTL and testbench

REQUEST_ENCODER -- requirements
Module: request_encoder

---
 rtl/request_encoder.sv | 116 +++++++++++
 tb/tb_request_encoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/request_encoder.sv
// Request encoder: captures single-cycle request events on four lines into a
// pending register and presents one granted index at a time through a
// registered valid/ready output stage.
//
// Parameters:
//   ROUND_ROBIN - 0: fixed priority, index 0 wins; 1: rotating priority
//                 starting after the last granted index.
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset      - synchronous active-high reset
//   in0..in3   - request lines; high in a cycle = one request event
//   ready      - consumer accepts the presented address when valid is high
//   address0   - registered LSB of the granted index
//   address1   - registered MSB of the granted index
//   valid      - registered; {address1,address0} holds a granted index
//   overrun    - registered one-cycle pulse; an event merged into a pending one
module request_encoder #(
    parameter int unsigned ROUND_ROBIN = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic ready,
    output logic address0,
    output logic address1,
    output logic valid,
    output logic overrun
);

    logic [3:0] pending_q, pending_d;
    logic [1:0] addr_q, addr_d;
    logic [1:0] ptr_q, ptr_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;

    logic [3:0] req;
    logic [3:0] clear;
    logic [1:0] base;
    logic [1:0] cand;
    logic [1:0] sel;
    logic       found;
    logic       free;
    logic       load;

    assign req = {in3, in2, in1, in0};

    // Output stage can take a new index when empty or being accepted now.
    assign free = !valid_q || ready;

    // Search origin: index 0 for fixed priority, one past the last grant
    // for rotating priority (2-bit arithmetic wraps 3 -> 0).
    assign base = (ROUND_ROBIN != 0) ? (ptr_q + 2'd1) : 2'd0;

    always_comb begin
        sel   = 2'd0;
        found = 1'b0;
        cand  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = base + 2'(k);
            if (!found && pending_q[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign load = free && found;

    always_comb begin
        clear = 4'b0000;
        if (load) begin
            clear[sel] = 1'b1;
        end
    end

    always_comb begin
        // A new event on a bit being cleared this edge re-sets it (set wins).
        pending_d = (pending_q & ~clear) | req;
        overrun_d = |(req & pending_q & ~clear);
        valid_d   = valid_q;
        addr_d    = addr_q;
        ptr_d     = ptr_q;
        if (free) begin
            valid_d = load;
        end
        if (load) begin
            addr_d = sel;
            ptr_d  = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 4'b0000;
            addr_q    <= 2'd0;
            ptr_q     <= 2'd3;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            addr_q    <= addr_d;
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign address0 = addr_q[0];
    assign address1 = addr_q[1];
    assign valid    = valid_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_request_encoder.sv
module tb_request_encoder;

    logic clk;
    logic reset;
    logic in0, in1, in2, in3;
    logic ready;
    logic fp_a0, fp_a1, fp_valid, fp_ovr;
    logic rr_a0, rr_a1, rr_valid, rr_ovr;

    int checks;
    int failures;

    // Reference state per instance: 0 = fixed priority, 1 = round robin.
    bit m_pend [2][4];
    bit m_valid[2];
    bit m_ovr  [2];
    int m_addr [2];
    int m_ptr  [2];

    request_encoder #(.ROUND_ROBIN(0)) u_fp (
        .clk      (clk),
        .reset    (reset),
        .in0      (in0),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .ready    (ready),
        .address0 (fp_a0),
        .address1 (fp_a1),
        .valid    (fp_valid),
        .overrun  (fp_ovr)
    );

    request_encoder #(.ROUND_ROBIN(1)) u_rr (
        .clk      (clk),
        .reset    (reset),
        .in0      (in0),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .ready    (ready),
        .address0 (rr_a0),
        .address1 (rr_a1),
        .valid    (rr_valid),
        .overrun  (rr_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One edge of the behavioural model for instance m.
    task automatic model_step(input int m, input logic [3:0] req, input logic rdy,
                              input logic rst);
        bit free;
        int grant;
        int idx;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_pend[m][i] = 0;
            m_valid[m] = 0;
            m_ovr[m]   = 0;
            m_addr[m]  = 0;
            m_ptr[m]   = 3;
            return;
        end
        free  = !m_valid[m] || rdy;
        grant = -1;
        if (free) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m == 0) ? k : (m_ptr[m] + 1 + k) % 4;
                if (grant < 0 && m_pend[m][idx]) grant = idx;
            end
        end
        m_ovr[m] = 0;
        for (int i = 0; i < 4; i++) begin
            if (req[i] && m_pend[m][i] && i != grant) m_ovr[m] = 1;
        end
        for (int i = 0; i < 4; i++) begin
            if (i == grant) m_pend[m][i] = 0;
            if (req[i]) m_pend[m][i] = 1;
        end
        if (free) begin
            m_valid[m] = (grant >= 0);
            if (grant >= 0) begin
                m_addr[m] = grant;
                m_ptr[m]  = grant;
            end
        end
    endtask

    task automatic step(input logic [3:0] req, input logic rdy, input logic rst);
        {in3, in2, in1, in0} = req;
        ready = rdy;
        reset = rst;
        model_step(0, req, rdy, rst);
        model_step(1, req, rdy, rst);
        @(posedge clk);
        #1;
        check("fp_valid", int'(fp_valid), int'(m_valid[0]));
        check("fp_addr", int'({fp_a1, fp_a0}), m_addr[0]);
        check("fp_ovr", int'(fp_ovr), int'(m_ovr[0]));
        check("rr_valid", int'(rr_valid), int'(m_valid[1]));
        check("rr_addr", int'({rr_a1, rr_a0}), m_addr[1]);
        check("rr_ovr", int'(rr_ovr), int'(m_ovr[1]));
    endtask

    initial begin
        logic [3:0] r;
        checks   = 0;
        failures = 0;
        reset = 1'b1;
        {in3, in2, in1, in0} = 4'b0000;
        ready = 1'b0;

        // Requests during reset are discarded.
        step(4'b1111, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b1);
        check("reset_valid", int'(fp_valid), 0);
        check("reset_addr", int'({fp_a1, fp_a0}), 0);

        // Single request: two edges to valid.
        step(4'b0100, 1'b1, 1'b0);
        check("single_lat1", int'(fp_valid), 0);
        step(4'b0000, 1'b1, 1'b0);
        check("single_valid", int'(fp_valid), 1);
        check("single_addr", int'({fp_a1, fp_a0}), 2);
        step(4'b0000, 1'b1, 1'b0);
        check("single_done", int'(fp_valid), 0);

        // Stall with three requests, then drain.
        step(4'b1011, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, 1'b0);
        check("stall_addr", int'({fp_a1, fp_a0}), 0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0);
        check("stall_drained", int'(fp_valid), 0);

        // Rotation: all lines high.
        step(4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, 1'b0);
        check("rot_ovr", int'(rr_ovr), 1);
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b1, 1'b0);

        // Overrun: second event on a pending index while output stalled.
        step(4'b0000, 1'b1, 1'b1);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        check("ovr_first", int'(fp_ovr), 0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        check("ovr_second", int'(fp_ovr), 1);
        step(4'b0000, 1'b0, 1'b0);
        check("ovr_pulse", int'(fp_ovr), 0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0);

        // Set/clear collision on index 3.
        step(4'b0000, 1'b1, 1'b1);
        step(4'b1000, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        check("coll_ovr", int'(fp_ovr), 0);
        check("coll_addr1", int'({fp_a1, fp_a0}), 3);
        step(4'b0000, 1'b1, 1'b0);
        check("coll_valid2", int'(fp_valid), 1);
        check("coll_addr2", int'({fp_a1, fp_a0}), 3);
        step(4'b0000, 1'b1, 1'b0);
        check("coll_done", int'(fp_valid), 0);

        // Reset mid-stream with pending 1010.
        step(4'b1011, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check("mid_valid", int'(fp_valid), 1);
        step(4'b0000, 1'b0, 1'b1);
        check("mid_rst_valid", int'(fp_valid), 0);
        check("mid_rst_addr", int'({fp_a1, fp_a0}), 0);
        check("mid_rst_ovr", int'(fp_ovr), 0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, 1'b0);
        check("mid_no_grant", int'(fp_valid), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) r = r & 4'($urandom_range(0, 15));
            step(r, 1'($urandom_range(0, 3) != 0 ? 1 : 0),
                 1'($urandom_range(0, 60) == 0 ? 1 : 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
